native_in_port_pack: RTL and testbench

Parametrised successor to the native video input port. Captures a DE/VSYNC-timed pixel stream, packs `PACK` pixels per output word and emits one-cycle frame-start (`falign`), line-end (`lalign`) and frame-end (`ealign`) markers aligned with the data. It also checks each line and frame against `hactive`/`vactive` and drops lines beyond `vactive`. It sits between the video timing source and the VDMA write-side FIFO.

---
 rtl/native_in_port_pack_if.sv | 29 ++
 rtl/native_in_port_pack.sv | 160 ++++++++++++++++
 tb/tb_native_in_port_pack.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/native_in_port_pack_if.sv
// rtl/native_in_port_pack_if.sv - timing-source side and packed-word side of the video input port
interface native_in_port_pack_if #(
  parameter int DSIZE = 24,
  parameter int PACK  = 2
);
  logic [15:0]           vactive;
  logic [15:0]           hactive;
  logic                  vsync;
  logic                  hsync;
  logic                  de;
  logic [DSIZE-1:0]      idata;
  logic                  falign;
  logic                  lalign;
  logic                  ealign;
  logic                  odata_vld;
  logic [DSIZE*PACK-1:0] odata;
  logic                  line_err;
  logic                  frame_err;

  modport master (
    output vactive, hactive, vsync, hsync, de, idata,
    input  falign, lalign, ealign, odata_vld, odata, line_err, frame_err
  );

  modport slave (
    input  vactive, hactive, vsync, hsync, de, idata,
    output falign, lalign, ealign, odata_vld, odata, line_err, frame_err
  );
endinterface

// File: rtl/native_in_port_pack.sv
// rtl/native_in_port_pack.sv - DE/VSYNC pixel capture, PACK-pixel word packing and frame markers
module native_in_port_pack #(
  parameter int    DSIZE  = 24,
  parameter int    PACK   = 2,
  parameter string VS_POL = "HIGH",
  parameter string MODE   = "LINE"
) (
  input logic                  clock,
  input logic                  rst,
  native_in_port_pack_if.slave bus
);
  localparam int              WW        = DSIZE * PACK;
  localparam int              SW        = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SW-1:0]   LAST_SLOT = SW'(PACK - 1);
  localparam bit              ONCE      = (MODE == "ONCE");
  localparam bit              VS_LOW    = (VS_POL == "LOW");

  typedef enum logic [1:0] {ST_WAIT, ST_ACTIVE, ST_BLANK} state_t;

  state_t           r_state;
  logic             r_vs1, r_vs1_q, r_de1, r_de1_q;
  logic [DSIZE-1:0] r_d1;
  logic [15:0]      r_vact, r_hact, r_line_cnt, r_pix_cnt;
  logic [WW-1:0]    r_acc, r_hold;
  logic [SW-1:0]    r_slot;
  logic             r_hold_vld, r_seen, r_fa_pend, r_fe_pend;
  logic             r_falign, r_lalign, r_ealign, r_vld, r_line_err, r_frame_err;
  logic [WW-1:0]    r_odata;

  logic             w_edge, w_line_end, w_last_line, w_unused;
  logic [15:0]      w_line_inc, w_pix_inc;
  logic [WW-1:0]    w_acc_fill;

  assign w_unused    = bus.hsync;
  assign w_edge      = r_vs1 & ~r_vs1_q;
  assign w_line_end  = r_de1_q & ~r_de1;
  assign w_line_inc  = (r_line_cnt == 16'hFFFF) ? r_line_cnt : r_line_cnt + 16'd1;
  assign w_pix_inc   = (r_pix_cnt == 16'hFFFF) ? r_pix_cnt : r_pix_cnt + 16'd1;
  assign w_last_line = (w_line_inc == r_vact);

  always_comb begin
    w_acc_fill = r_acc;
    w_acc_fill[r_slot*DSIZE +: DSIZE] = r_d1;
  end

  // vsync history resets to "active" so a frame needs a genuine inactive->active transition
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= ST_WAIT;
      r_vs1       <= 1'b1;
      r_vs1_q     <= 1'b1;
      r_de1       <= 1'b0;
      r_de1_q     <= 1'b0;
      r_d1        <= '0;
      r_vact      <= '0;
      r_hact      <= '0;
      r_line_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_acc       <= '0;
      r_hold      <= '0;
      r_slot      <= '0;
      r_hold_vld  <= 1'b0;
      r_seen      <= 1'b0;
      r_fa_pend   <= 1'b0;
      r_fe_pend   <= 1'b0;
      r_falign    <= 1'b0;
      r_lalign    <= 1'b0;
      r_ealign    <= 1'b0;
      r_vld       <= 1'b0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_odata     <= '0;
    end else begin
      r_vs1       <= VS_LOW ? ~bus.vsync : bus.vsync;
      r_vs1_q     <= r_vs1;
      r_de1       <= bus.de;
      r_de1_q     <= r_de1;
      r_d1        <= bus.idata;
      r_fa_pend   <= 1'b0;
      r_fe_pend   <= 1'b0;
      r_falign    <= r_fa_pend;
      r_frame_err <= r_fe_pend;
      r_vld       <= 1'b0;
      r_lalign    <= 1'b0;
      r_ealign    <= 1'b0;
      r_line_err  <= 1'b0;
      if (w_edge) begin
        // extra pend stage keeps falign two clocks after capture, ahead of the first word
        r_fa_pend  <= 1'b1;
        r_fe_pend  <= r_seen && (r_line_cnt != r_vact);
        r_seen     <= 1'b1;
        r_vact     <= (bus.vactive == 16'd0) ? 16'd1 : bus.vactive;
        r_hact     <= bus.hactive;
        r_line_cnt <= '0;
        r_state    <= ST_ACTIVE;
        r_hold     <= '0;
        r_hold_vld <= 1'b0;
        r_acc      <= '0;
        r_slot     <= '0;
        r_pix_cnt  <= '0;
        if (r_de1) begin
          r_pix_cnt <= 16'd1;
          if (PACK == 1) begin
            r_hold     <= WW'(r_d1);
            r_hold_vld <= 1'b1;
          end else begin
            r_acc  <= WW'(r_d1);
            r_slot <= SW'(1);
          end
        end
      end else begin
        case (r_state)
          ST_ACTIVE: begin
            if (r_de1) begin
              r_pix_cnt <= w_pix_inc;
              if (r_hold_vld) begin
                r_vld   <= 1'b1;
                r_odata <= r_hold;
              end
              if (r_slot == LAST_SLOT) begin
                r_hold     <= w_acc_fill;
                r_hold_vld <= 1'b1;
                r_acc      <= '0;
                r_slot     <= '0;
              end else begin
                r_hold_vld <= 1'b0;
                r_acc      <= w_acc_fill;
                r_slot     <= r_slot + SW'(1);
              end
            end else if (w_line_end) begin
              r_vld      <= 1'b1;
              r_odata    <= r_hold_vld ? r_hold : r_acc;
              r_lalign   <= ONCE ? w_last_line : 1'b1;
              r_ealign   <= w_last_line;
              r_line_err <= (r_pix_cnt != r_hact);
              r_line_cnt <= w_line_inc;
              r_hold_vld <= 1'b0;
              r_acc      <= '0;
              r_slot     <= '0;
              r_pix_cnt  <= '0;
              if (w_last_line) r_state <= ST_BLANK;
            end
          end
          ST_BLANK: begin
            if (w_line_end) r_line_cnt <= w_line_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.falign    = r_falign;
  assign bus.lalign    = r_lalign;
  assign bus.ealign    = r_ealign;
  assign bus.odata_vld = r_vld;
  assign bus.odata     = r_odata;
  assign bus.line_err  = r_line_err;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_native_in_port_pack.sv
// tb/tb_native_in_port_pack.sv - bench for native_in_port_pack: PACK=4/HIGH/LINE and PACK=2/LOW/ONCE against a line-level model
module tb_native_in_port_pack;
  localparam int MAXC = 4096;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  native_in_port_pack_if #(.DSIZE(8), .PACK(4)) bus_a ();
  native_in_port_pack_if #(.DSIZE(8), .PACK(2)) bus_b ();

  native_in_port_pack #(.DSIZE(8), .PACK(4), .VS_POL("HIGH"), .MODE("LINE")) dut_a (
    .clock(clock), .rst(rst), .bus(bus_a)
  );
  native_in_port_pack #(.DSIZE(8), .PACK(2), .VS_POL("LOW"), .MODE("ONCE")) dut_b (
    .clock(clock), .rst(rst), .bus(bus_b)
  );

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int v_cur, h_cur;

  // expected outputs per cycle: {falign, lalign, ealign, vld, line_err, frame_err, odata[31:0]}
  logic [37:0] m_exp [2][MAXC];
  logic [7:0]  m_pix [2][64];
  int          m_mode [2];
  int          m_n [2];
  int          m_lines [2];
  int          m_vact [2];
  int          m_hact [2];
  bit          m_seen [2];
  bit          m_pde [2];
  bit          m_pnv [2];
  logic [37:0] obs_a, obs_b;

  task automatic model_reset(input int t);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) m_exp[k][t+j] = '0;
      m_mode[k] = 0; m_n[k] = 0; m_lines[k] = 0;
      m_seen[k] = 1'b0; m_pde[k] = 1'b0; m_pnv[k] = 1'b1;
    end
  endtask

  task automatic exp_word(input int k, input int t, input int start, input int cnt);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < cnt; i++) w[i*8 +: 8] = m_pix[k][start+i];
    m_exp[k][t][34]   = 1'b1;
    m_exp[k][t][31:0] = w;
  endtask

  task automatic model_step(input int k, input int t, input bit nv, input bit de, input logic [7:0] d);
    int p, start, lines_next;
    bit once, last;
    p    = (k == 0) ? 4 : 2;
    once = (k == 1);
    if (nv && !m_pnv[k]) begin
      m_exp[k][t+2][37] = 1'b1;
      m_exp[k][t+2][32] = m_seen[k] && (m_lines[k] != m_vact[k]);
      m_seen[k] = 1'b1;
      m_vact[k] = (v_cur == 0) ? 1 : v_cur;
      m_hact[k] = h_cur;
      m_lines[k] = 0; m_mode[k] = 1; m_n[k] = 0;
      if (de) begin m_pix[k][0] = d; m_n[k] = 1; end
    end else if (m_mode[k] == 1) begin
      if (de) begin
        if (m_n[k] > 0 && m_n[k] % p == 0) exp_word(k, t + 1, m_n[k] - p, p);
        m_pix[k][m_n[k]] = d;
        m_n[k]++;
      end else if (m_pde[k]) begin
        lines_next = (m_lines[k] < 65535) ? m_lines[k] + 1 : m_lines[k];
        last  = (lines_next == m_vact[k]);
        start = ((m_n[k] - 1) / p) * p;
        exp_word(k, t + 1, start, m_n[k] - start);
        m_exp[k][t+1][36] = once ? last : 1'b1;
        m_exp[k][t+1][35] = last;
        m_exp[k][t+1][33] = (m_n[k] != m_hact[k]);
        m_lines[k] = lines_next;
        m_n[k] = 0;
        if (last) m_mode[k] = 2;
      end
    end else if (m_mode[k] == 2) begin
      if (!de && m_pde[k] && m_lines[k] < 65535) m_lines[k]++;
    end
    m_pde[k] = de;
    m_pnv[k] = nv;
  endtask

  task automatic tick(input bit vs, input bit de_i, input logic [7:0] d);
    bus_a.vsync = vs;   bus_b.vsync = ~vs;
    bus_a.de    = de_i; bus_b.de    = de_i;
    bus_a.idata = d;    bus_b.idata = d;
    bus_a.hsync = 1'($urandom);
    bus_b.hsync = 1'($urandom);
    @(posedge clock);
    cyc++;
    if (cyc + 3 >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst) model_reset(cyc);
    else begin
      model_step(0, cyc, vs, de_i, d);
      model_step(1, cyc, vs, de_i, d);
    end
    #1;
    obs_a = {bus_a.falign, bus_a.lalign, bus_a.ealign, bus_a.odata_vld, bus_a.line_err,
             bus_a.frame_err, bus_a.odata_vld ? bus_a.odata : 32'h0};
    obs_b = {bus_b.falign, bus_b.lalign, bus_b.ealign, bus_b.odata_vld, bus_b.line_err,
             bus_b.frame_err, 16'h0, bus_b.odata_vld ? bus_b.odata : 16'h0};
    vectors += 2;
    assert (obs_a === m_exp[0][cyc]) else begin
      miscompares++;
      $error("FAIL dut_a cyc=%0d observed=%h expected=%h", cyc, obs_a, m_exp[0][cyc]);
    end
    assert (obs_b === m_exp[1][cyc]) else begin
      miscompares++;
      $error("FAIL dut_b cyc=%0d observed=%h expected=%h", cyc, obs_b, m_exp[1][cyc]);
    end
  endtask

  task automatic check_odata_zero(input string tag);
    vectors++;
    assert ({bus_a.odata, bus_b.odata} === 48'h0) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=0", tag, {bus_a.odata, bus_b.odata});
    end
  endtask

  task automatic frame_cfg(input int v, input int h);
    v_cur = v; h_cur = h;
    bus_a.vactive = 16'(v); bus_b.vactive = 16'(v);
    bus_a.hactive = 16'(h); bus_b.hactive = 16'(h);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input int n, input bit seq);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, seq ? 8'(i + 1) : 8'($urandom));
    tick(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int v, h, nl, n;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < MAXC; c++) m_exp[k][c] = '0;
    frame_cfg(1, 1);

    // reset state
    rst = 1'b1;
    idle(3);
    check_odata_zero("reset_odata");
    rst = 1'b0;

    // lines without any frame edge produce nothing
    idle(2);
    line(6, 1'b0);
    line(3, 1'b0);

    // basic packing, pixels 1..4, two lines
    frame_cfg(2, 4);
    idle(2);
    vs_pulse();
    idle(1);
    line(4, 1'b1);
    idle(1);
    line(4, 1'b1);
    idle(3);

    // partial flush, short line, then a line dropped in BLANK
    frame_cfg(2, 6);
    vs_pulse();
    idle(2);
    line(6, 1'b1);
    line(5, 1'b1);
    line(6, 1'b0);
    idle(2);

    // short frame, then restart in the middle of a line
    frame_cfg(3, 6);
    vs_pulse();
    idle(1);
    line(6, 1'b1);
    frame_cfg(3, 5);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom));
    tick(1'b1, 1'b1, 8'h55);
    tick(1'b1, 1'b1, 8'h66);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom));
    tick(1'b0, 1'b0, 8'h00);
    line(5, 1'b0);
    idle(2);

    // vactive of zero behaves as one
    frame_cfg(0, 3);
    vs_pulse();
    line(3, 1'b1);
    line(3, 1'b1);
    idle(2);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      v = $urandom_range(0, 4);
      h = $urandom_range(1, 9);
      frame_cfg(v, h);
      idle(1);
      vs_pulse();
      idle($urandom_range(0, 2));
      nl = $urandom_range(0, 5);
      for (int l = 0; l < nl; l++) begin
        n = h + $urandom_range(0, 2) - 1;
        if (n < 1) n = 1;
        line(n, 1'b0);
        idle($urandom_range(0, 2));
      end
    end

    // reset in the middle of a line, then lines with no frame edge
    frame_cfg(2, 4);
    vs_pulse();
    line(4, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom));
    rst = 1'b1;
    tick(1'b0, 1'b1, 8'($urandom));
    tick(1'b0, 1'b1, 8'($urandom));
    rst = 1'b0;
    tick(1'b0, 1'b1, 8'($urandom));
    tick(1'b0, 1'b0, 8'h00);
    check_odata_zero("post_reset_odata");
    line(4, 1'b0);
    line(4, 1'b0);
    vs_pulse();
    line(4, 1'b1);
    line(4, 1'b1);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
